// File: rtl/de_pipe_reg.sv
// D/E pipeline register: latches decoded operands every cycle, derives the
// execute-stage hazard metadata (A3, RegWrite, Tnew, valid) and counts bubbles.
module de_pipe_reg #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] RESET_PC = 32'h00003000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             FlushE,
    input  logic [31:0]      IR_D,
    input  logic [31:0]      PC_D,
    input  logic [31:0]      RD1_D,
    input  logic [31:0]      RD2_D,
    input  logic [31:0]      EXT_D,
    output logic [31:0]      IR_E,
    output logic [31:0]      PC_E,
    output logic [31:0]      PC8_E,
    output logic [31:0]      RS_E,
    output logic [31:0]      RT_E,
    output logic [31:0]      EXT_E,
    output logic [4:0]       A3_E,
    output logic             RegWrite_E,
    output logic [1:0]       Tnew_E,
    output logic             valid_E,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_CAL_R,
        CLS_CAL_I,
        CLS_LOAD,
        CLS_SAVE,
        CLS_BEQ,
        CLS_J,
        CLS_JAL,
        CLS_JR
    } instr_class_e;

    logic [5:0]   op_d;
    logic [5:0]   funct_d;
    instr_class_e cls_d;
    logic [4:0]   a3_d;
    logic         regwrite_d;
    logic [1:0]   tnew_d;

    logic [31:0]      ir_q, pc_q, pc8_q, rs_q, rt_q, ext_q;
    logic [4:0]       a3_q;
    logic             regwrite_q;
    logic [1:0]       tnew_q;
    logic             valid_q;
    logic [CNT_W-1:0] bubble_cnt_q;

    assign op_d    = IR_D[31:26];
    assign funct_d = IR_D[5:0];

    always_comb begin
        cls_d = CLS_NONE;
        case (op_d)
            6'b000000: begin
                if (funct_d == 6'b100001 || funct_d == 6'b100011) cls_d = CLS_CAL_R;
                else if (funct_d == 6'b001000)                    cls_d = CLS_JR;
            end
            6'b001101, 6'b001111: cls_d = CLS_CAL_I;
            6'b100011:            cls_d = CLS_LOAD;
            6'b101011:            cls_d = CLS_SAVE;
            6'b000100:            cls_d = CLS_BEQ;
            6'b000010:            cls_d = CLS_J;
            6'b000011:            cls_d = CLS_JAL;
            default:              cls_d = CLS_NONE;
        endcase
    end

    always_comb begin
        a3_d       = 5'd0;
        regwrite_d = 1'b0;
        tnew_d     = 2'd0;
        case (cls_d)
            CLS_CAL_R: begin a3_d = IR_D[15:11]; tnew_d = 2'd1; end
            CLS_CAL_I: begin a3_d = IR_D[20:16]; tnew_d = 2'd1; end
            CLS_LOAD:  begin a3_d = IR_D[20:16]; tnew_d = 2'd2; end
            CLS_JAL:   begin a3_d = 5'd31;       tnew_d = 2'd0; end
            default:   begin a3_d = 5'd0;        tnew_d = 2'd0; end
        endcase
        // $0 is never a real destination, so hazard logic must not see a write.
        regwrite_d = (cls_d == CLS_CAL_R || cls_d == CLS_CAL_I ||
                      cls_d == CLS_LOAD  || cls_d == CLS_JAL) && (a3_d != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q         <= '0;
            pc_q         <= RESET_PC;
            pc8_q        <= RESET_PC + 32'd8;
            rs_q         <= '0;
            rt_q         <= '0;
            ext_q        <= '0;
            a3_q         <= '0;
            regwrite_q   <= 1'b0;
            tnew_q       <= '0;
            valid_q      <= 1'b0;
            bubble_cnt_q <= '0;
        end else if (FlushE) begin
            // The PC still advances so a bubble can be traced back to its slot.
            ir_q         <= '0;
            pc_q         <= PC_D;
            pc8_q        <= PC_D + 32'd8;
            rs_q         <= '0;
            rt_q         <= '0;
            ext_q        <= '0;
            a3_q         <= '0;
            regwrite_q   <= 1'b0;
            tnew_q       <= '0;
            valid_q      <= 1'b0;
            if (bubble_cnt_q != {CNT_W{1'b1}}) bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end else begin
            ir_q       <= IR_D;
            pc_q       <= PC_D;
            pc8_q      <= PC_D + 32'd8;
            rs_q       <= RD1_D;
            rt_q       <= RD2_D;
            ext_q      <= EXT_D;
            a3_q       <= a3_d;
            regwrite_q <= regwrite_d;
            tnew_q     <= tnew_d;
            valid_q    <= 1'b1;
        end
    end

    assign IR_E       = ir_q;
    assign PC_E       = pc_q;
    assign PC8_E      = pc8_q;
    assign RS_E       = rs_q;
    assign RT_E       = rt_q;
    assign EXT_E      = ext_q;
    assign A3_E       = a3_q;
    assign RegWrite_E = regwrite_q;
    assign Tnew_E     = tnew_q;
    assign valid_E    = valid_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: doc/de_pipe_reg.md
Name: de_pipe_reg

Overview:
- D/E pipeline register of the 5-stage MIPS core (lw, sw, addu, subu, beq, ori, lui, j, jal, jr).
- Sits between decode and execute, and consumes the FlushE output of the hazard/stall unit to insert bubbles.
- Latches the decoded operands each cycle and derives the execute-stage metadata that the hazard and forwarding logic read: destination register, write enable, Tnew and valid.
- Keeps a saturating count of inserted bubbles for performance debug.

Parameters:
- CNT_W, 16: width of the bubble counter.
- RESET_PC, 32'h00003000: value PC_E takes on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- FlushE  input  1  from the stall unit; 1 = load a bubble this edge.
- IR_D  input  32  instruction in D.
- PC_D  input  32  PC of the D instruction.
- RD1_D  input  32  rs operand after D-stage forwarding.
- RD2_D  input  32  rt operand after D-stage forwarding.
- EXT_D  input  32  extended immediate.
- IR_E  output  32  latched instruction.
- PC_E  output  32  latched PC.
- PC8_E  output  32  PC_E + 8, the jal link value.
- RS_E  output  32  latched rs operand.
- RT_E  output  32  latched rt operand.
- EXT_E  output  32  latched immediate.
- A3_E  output  5  destination register of the E instruction.
- RegWrite_E  output  1  the E instruction writes the register file.
- Tnew_E  output  2  cycles until the E result can be forwarded.
- valid_E  output  1  the E slot holds a real instruction, not a bubble.
- bubble_cnt  output  CNT_W  saturating count of bubbles inserted.

Behaviour:
- All outputs are registered; latency is exactly 1 cycle from D inputs to E outputs. There is no enable: the register loads every cycle.
- Update priority each edge is reset > FlushE > normal load.
- Reset response:
  - IR_E, RS_E, RT_E and EXT_E go to 0.
  - PC_E goes to RESET_PC and PC8_E to RESET_PC+8.
  - A3_E, RegWrite_E, Tnew_E and valid_E go to 0.
  - bubble_cnt goes to 0.
  - Reset asserted mid-run overrides any FlushE in the same cycle and does not increment the counter.
- FlushE=1 (and reset=0):
  - IR_E, RS_E, RT_E, EXT_E, A3_E, RegWrite_E, Tnew_E and valid_E go to 0.
  - PC_E takes PC_D and PC8_E takes PC_D+8, so the PC stays traceable through the bubble.
  - bubble_cnt increments by 1 and saturates at all-ones; it never wraps.
- Normal load: all data outputs take their D-side values, PC8_E = PC_D+8 (32-bit, wrap ignored), and valid_E = 1.
- Decode of IR_D into a class, computed combinationally and then registered:
  - CAL_R: op=0 with funct 100001 (addu) or 100011 (subu).
  - CAL_I: op 001101 (ori) or 001111 (lui).
  - LOAD: op 100011. SAVE: op 101011. BEQ: op 000100.
  - J: op 000010. JAL: op 000011. JR: op=0 with funct 001000.
  - Anything else, including IR=0 (sll $0 nop), is NONE.
- A3_E per class: rd (IR[15:11]) for CAL_R; rt (IR[20:16]) for CAL_I and LOAD; 31 for JAL; 0 for all other classes.
- RegWrite_E = 1 only if the class is CAL_R, CAL_I, LOAD or JAL and the computed A3 != 0. A write to $0 is reported as no write.
- Tnew_E per class: CAL_R and CAL_I = 1; LOAD = 2; JAL = 0, since PC8 is available immediately; all others = 0.
- Back-to-back flushes insert one bubble per asserted cycle. A flush pulse therefore drops exactly the D instruction presented on that edge, and the stall unit must hold D.

Test Plan:
1. Assert reset for 2 cycles with random D inputs, then release. Required: IR_E=0, PC_E=0x00003000, PC8_E=0x00003008, RegWrite_E=0, valid_E=0, bubble_cnt=0 during reset.
2. Present IR_D=0x00851821 (addu $3,$4,$5), PC_D=0x3004, RD1_D=7, RD2_D=9 with no flush. Required one cycle later: A3_E=3, RegWrite_E=1, Tnew_E=1, valid_E=1, RS_E=7, RT_E=9, PC8_E=0x300C.
3. Present lw $8,4($9) (0x8D280004) followed by jal (0x0C000C10) at PC 0x3010. Required: first A3_E=8, Tnew_E=2; then A3_E=31, Tnew_E=0, PC8_E=0x3018.
4. Present ori $0,$1,5 (0x34200005) and jr $31 (0x03E00008). Required: A3_E=0 and RegWrite_E=0 for both; valid_E=1.
5. Assert FlushE for 3 consecutive cycles with IR_D=addu and PC_D=0x3020. Required: IR_E=0, RegWrite_E=0, valid_E=0, PC_E=0x3020 each cycle, and bubble_cnt increases from 0 to 3.
6. Run with CNT_W=2 and 5 flushes, then assert reset together with FlushE. Required: bubble_cnt reads 1, 2, 3, 3, 3, then 0 after the reset edge.
